// File: rtl/traffic_timing_core_pkg.sv
// Shared definitions for the traffic light timing core: light state codes,
// mode codes, tick divider default, default durations and the display limit.
package traffic_timing_core_pkg;

  // Light state codes; lane1 is the first letter of the name.
  typedef enum logic [2:0] {
    ST_RR = 3'd0,
    ST_GG = 3'd1,
    ST_YY = 3'd2,
    ST_RG = 3'd3,
    ST_RY = 3'd4,
    ST_GR = 3'd5,
    ST_YR = 3'd6
  } light_state_t;

  // One-hot operating modes; anything not one-hot behaves as manual.
  localparam logic [2:0] MODE_AUTO   = 3'b100;
  localparam logic [2:0] MODE_CONFIG = 3'b010;
  localparam logic [2:0] MODE_MANUAL = 3'b001;

  localparam int DIV_CYCLES       = 125_000_000;
  localparam int GREEN_DEFAULT_S  = 25;
  localparam int YELLOW_DEFAULT_S = 3;
  localparam int DISPLAY_MAX      = 99;
  localparam int TIME_W           = 7;

endpackage

// File: rtl/traffic_timing_core_clk_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV cycles.
module clk_tick_gen #(
  parameter int DIV = 125_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  // Count 0..DIV-1 and wrap; the tick is the terminal count itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/traffic_timing_core.sv
// Timing core of a two-lane traffic light: 1 Hz tick, automatic light cycle
// RG->RY->GR->YR, and a config editor for the green/yellow durations.
module traffic_timing_core
  import traffic_timing_core_pkg::*;
#(
  parameter int DIV            = DIV_CYCLES,
  parameter int GREEN_DEFAULT  = GREEN_DEFAULT_S,
  parameter int YELLOW_DEFAULT = YELLOW_DEFAULT_S
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        mode,
  input  logic              btn_light,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              btn_confirm,
  output logic              tick,
  output logic [2:0]        state,
  output logic [TIME_W-1:0] time_lane1,
  output logic [TIME_W-1:0] time_lane2,
  output logic [TIME_W-1:0] green_time,
  output logic [TIME_W-1:0] yellow_time,
  output logic [TIME_W-1:0] red_time
);

  localparam logic [TIME_W-1:0] G_DEF = TIME_W'(GREEN_DEFAULT);
  localparam logic [TIME_W-1:0] Y_DEF = TIME_W'(YELLOW_DEFAULT);

  logic [2:0]        mode_prev_reg;
  logic [3:0]        btn_prev_reg;
  logic [3:0]        btn_now;
  logic [3:0]        btn_edge;
  logic              auto_active, cfg_active, enter_auto, enter_cfg;
  logic              light_edge, inc_edge, dec_edge, confirm_edge;

  light_state_t      state_reg, state_next;
  logic [TIME_W-1:0] cnt_reg, cnt_next;

  light_state_t      sel_reg, sel_next;
  logic [TIME_W-1:0] edit_g_reg, edit_g_next;
  logic [TIME_W-1:0] edit_y_reg, edit_y_next;
  logic [TIME_W-1:0] green_reg, green_next;
  logic [TIME_W-1:0] yellow_reg, yellow_next;
  logic [TIME_W:0]   edit_sum;

  clk_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign auto_active = (mode == MODE_AUTO);
  assign cfg_active  = (mode == MODE_CONFIG);
  assign enter_auto  = auto_active && (mode_prev_reg != MODE_AUTO);
  assign enter_cfg   = cfg_active && (mode_prev_reg != MODE_CONFIG);

  // Button edges only matter while editing, and not in the entry cycle,
  // where the editor is being (re)loaded from the committed values.
  assign btn_now      = {btn_confirm, btn_dec, btn_inc, btn_light};
  assign btn_edge     = btn_now & ~btn_prev_reg & {4{cfg_active && !enter_cfg}};
  assign light_edge   = btn_edge[0];
  assign inc_edge     = btn_edge[1];
  assign dec_edge     = btn_edge[2];
  assign confirm_edge = btn_edge[3];
  assign edit_sum     = {1'b0, edit_g_reg} + {1'b0, edit_y_reg};

  // Remember last mode and button levels for change/edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_prev_reg <= 3'b000;
      btn_prev_reg  <= 4'b0000;
    end else begin
      mode_prev_reg <= mode;
      btn_prev_reg  <= btn_now;
    end
  end

  // Auto FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_RG;
      cnt_reg   <= G_DEF;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Auto FSM next state: restart on entry, count down per tick, load next phase at 1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (enter_auto) begin
      state_next = ST_RG;
      cnt_next   = green_reg;
    end else if (auto_active && tick) begin
      if (cnt_reg > TIME_W'(1)) begin
        cnt_next = cnt_reg - 1'b1;
      end else begin
        case (state_reg)
          ST_RG:   begin state_next = ST_RY; cnt_next = yellow_reg; end
          ST_RY:   begin state_next = ST_GR; cnt_next = green_reg;  end
          ST_GR:   begin state_next = ST_YR; cnt_next = yellow_reg; end
          default: begin state_next = ST_RG; cnt_next = green_reg;  end
        endcase
      end
    end
  end

  // Config editor and committed durations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_reg    <= ST_GG;
      edit_g_reg <= G_DEF;
      edit_y_reg <= Y_DEF;
      green_reg  <= G_DEF;
      yellow_reg <= Y_DEF;
    end else begin
      sel_reg    <= sel_next;
      edit_g_reg <= edit_g_next;
      edit_y_reg <= edit_y_next;
      green_reg  <= green_next;
      yellow_reg <= yellow_next;
    end
  end

  // Editor next values; confirm commits the pre-edit registers of this cycle.
  always_comb begin
    sel_next    = sel_reg;
    edit_g_next = edit_g_reg;
    edit_y_next = edit_y_reg;
    green_next  = green_reg;
    yellow_next = yellow_reg;
    if (enter_cfg) begin
      sel_next    = ST_GG;
      edit_g_next = green_reg;
      edit_y_next = yellow_reg;
    end else begin
      if (confirm_edge) begin
        green_next  = edit_g_reg;
        yellow_next = edit_y_reg;
      end
      if (light_edge) begin
        case (sel_reg)
          ST_GG:   sel_next = ST_YY;
          ST_YY:   sel_next = ST_RR;
          default: sel_next = ST_GG;
        endcase
      end
      if (inc_edge && !dec_edge && (edit_sum < (TIME_W + 1)'(DISPLAY_MAX))) begin
        if (sel_reg == ST_GG) edit_g_next = edit_g_reg + 1'b1;
        if (sel_reg == ST_YY) edit_y_next = edit_y_reg + 1'b1;
      end
      if (dec_edge && !inc_edge) begin
        if (sel_reg == ST_GG && edit_g_reg > TIME_W'(1)) edit_g_next = edit_g_reg - 1'b1;
        if (sel_reg == ST_YY && edit_y_reg > TIME_W'(1)) edit_y_next = edit_y_reg - 1'b1;
      end
    end
  end

  // Output mux: config view while editing, auto view in every other mode.
  always_comb begin
    state      = state_reg;
    time_lane1 = cnt_reg;
    time_lane2 = cnt_reg;
    if (cfg_active) begin
      state = sel_reg;
      case (sel_reg)
        ST_GG:   begin time_lane1 = edit_g_reg; time_lane2 = edit_g_reg; end
        ST_YY:   begin time_lane1 = edit_y_reg; time_lane2 = edit_y_reg; end
        default: begin
          time_lane1 = edit_sum[TIME_W-1:0];
          time_lane2 = edit_sum[TIME_W-1:0];
        end
      endcase
    end else begin
      if (state_reg == ST_RG) time_lane1 = cnt_reg + yellow_reg;
      if (state_reg == ST_GR) time_lane2 = cnt_reg + yellow_reg;
    end
  end

  assign green_time  = green_reg;
  assign yellow_time = yellow_reg;
  assign red_time    = green_reg + yellow_reg;

endmodule

// File: tb/tb_traffic_timing_core.sv
// Randomized + directed bench for traffic_timing_core against a behavioural model.
module tb_traffic_timing_core;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] mode = 3'b100;
  logic       btn_light = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_confirm = 1'b0;
  logic       tick;
  logic [2:0] state;
  logic [6:0] time_lane1, time_lane2, green_time, yellow_time, red_time;

  traffic_timing_core #(.DIV(DIV), .GREEN_DEFAULT(25), .YELLOW_DEFAULT(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .btn_light   (btn_light),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .btn_confirm (btn_confirm),
    .tick        (tick),
    .state       (state),
    .time_lane1  (time_lane1),
    .time_lane2  (time_lane2),
    .green_time  (green_time),
    .yellow_time (yellow_time),
    .red_time    (red_time)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: phase index 0..3 = RG,RY,GR,YR; selection 0..2 = GG,YY,RR.
  int m_div, m_phase, m_cnt, m_g, m_y, m_eg, m_ey, m_sel;
  logic [2:0] m_prev_mode;
  logic [3:0] m_prev_btn;
  int phase_code[4] = '{3, 4, 5, 6};
  int sel_code[3]   = '{1, 2, 0};

  task automatic model_reset();
    m_div = 0; m_phase = 0; m_cnt = 25; m_g = 25; m_y = 3;
    m_eg = 25; m_ey = 3; m_sel = 0; m_prev_mode = 3'b000; m_prev_btn = 4'b0000;
  endtask

  task automatic compare_all();
    int e_st, e_t1, e_t2;
    if (mode == 3'b010) begin
      e_st = sel_code[m_sel];
      e_t1 = (m_sel == 0) ? m_eg : (m_sel == 1) ? m_ey : m_eg + m_ey;
      e_t2 = e_t1;
    end else begin
      e_st = phase_code[m_phase];
      e_t1 = m_cnt + ((m_phase == 0) ? m_y : 0);
      e_t2 = m_cnt + ((m_phase == 2) ? m_y : 0);
    end
    check_val("tick",   int'(tick), (m_div == DIV - 1) ? 1 : 0);
    check_val("state",  int'(state), e_st);
    check_val("t1",     int'(time_lane1), e_t1);
    check_val("t2",     int'(time_lane2), e_t2);
    check_val("green",  int'(green_time), m_g);
    check_val("yellow", int'(yellow_time), m_y);
    check_val("red",    int'(red_time), m_g + m_y);
  endtask

  task automatic model_advance();
    logic [3:0] b, edge_b;
    logic tk;
    tk = (m_div == DIV - 1);
    m_div = tk ? 0 : m_div + 1;
    b = {btn_confirm, btn_dec, btn_inc, btn_light};
    edge_b = b & ~m_prev_btn;
    if (mode == 3'b100) begin
      if (m_prev_mode != 3'b100) begin
        m_phase = 0; m_cnt = m_g;
      end else if (tk) begin
        if (m_cnt > 1) m_cnt--;
        else begin
          m_phase = (m_phase + 1) % 4;
          m_cnt = (m_phase % 2 == 0) ? m_g : m_y;
        end
      end
    end
    if (mode == 3'b010) begin
      if (m_prev_mode != 3'b010) begin
        m_sel = 0; m_eg = m_g; m_ey = m_y;
      end else begin
        int old_sel;
        old_sel = m_sel;
        if (edge_b[3]) begin m_g = m_eg; m_y = m_ey; end
        if (edge_b[0]) m_sel = (m_sel + 1) % 3;
        if (edge_b[1] && !edge_b[2] && (m_eg + m_ey < 99)) begin
          if (old_sel == 0) m_eg++;
          if (old_sel == 1) m_ey++;
        end
        if (edge_b[2] && !edge_b[1]) begin
          if (old_sel == 0 && m_eg > 1) m_eg--;
          if (old_sel == 1 && m_ey > 1) m_ey--;
        end
      end
    end
    m_prev_mode = mode;
    m_prev_btn = b;
  endtask

  // One clock: drive at negedge, check, advance model, wait for next negedge.
  task automatic step(input logic [2:0] md, input logic [3:0] btns);
    mode = md;
    {btn_confirm, btn_dec, btn_inc, btn_light} = btns;
    #1;
    compare_all();
    model_advance();
    @(negedge clk);
  endtask

  task automatic press(input logic [2:0] md, input logic [3:0] btns);
    step(md, btns);
    step(md, 4'b0000);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_state"}, int'(state), 3);
    check_val({tag, "_t1"}, int'(time_lane1), 28);
    check_val({tag, "_t2"}, int'(time_lane2), 25);
    check_val({tag, "_green"}, int'(green_time), 25);
    check_val({tag, "_yellow"}, int'(yellow_time), 3);
    check_val({tag, "_red"}, int'(red_time), 28);
    check_val({tag, "_tick"}, int'(tick), 0);
  endtask

  logic [2:0] illegal_modes[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // Auto cycle: 25 ticks to RY, 3 to GR, 28 back to RG.
    repeat (25 * DIV) step(3'b100, 4'b0000);
    check_val("auto_ry_state", int'(state), 4);
    check_val("auto_ry_t1", int'(time_lane1), 3);
    check_val("auto_ry_t2", int'(time_lane2), 3);
    repeat (3 * DIV) step(3'b100, 4'b0000);
    check_val("auto_gr_state", int'(state), 5);
    check_val("auto_gr_t1", int'(time_lane1), 25);
    check_val("auto_gr_t2", int'(time_lane2), 28);
    repeat (28 * DIV) step(3'b100, 4'b0000);
    check_val("auto_rg_state", int'(state), 3);

    // Config: enter, inc x3, confirm.
    step(3'b010, 4'b0000);
    check_val("cfg_entry_state", int'(state), 1);
    check_val("cfg_entry_t1", int'(time_lane1), 25);
    repeat (3) press(3'b010, 4'b0010);
    press(3'b010, 4'b1000);
    check_val("cfg_green", int'(green_time), 28);
    check_val("cfg_red", int'(red_time), 31);

    // Select YY, dec three times from 3: floor at 1.
    press(3'b010, 4'b0001);
    repeat (3) press(3'b010, 4'b0100);
    check_val("cfg_yy_state", int'(state), 2);
    check_val("cfg_yy_floor", int'(time_lane1), 1);
    press(3'b010, 4'b0001);
    press(3'b010, 4'b0010);

    // Leave without confirm: edits discarded, auto restarts at RG.
    step(3'b100, 4'b0000);
    check_val("discard_yellow", int'(yellow_time), 3);
    check_val("discard_green", int'(green_time), 28);
    check_val("restart_state", int'(state), 3);
    check_val("restart_t2", int'(time_lane2), 28);

    // Randomized mode segments with random button levels.
    for (int seg = 0; seg < 24; seg++) begin
      logic [2:0] md;
      int kind, len;
      kind = $urandom_range(0, 9);
      if (kind <= 4) md = 3'b100;
      else if (kind <= 7) md = 3'b010;
      else if (kind == 8) md = 3'b001;
      else md = illegal_modes[$urandom_range(0, 4)];
      len = $urandom_range(20, 200);
      for (int c = 0; c < len; c++) begin
        logic [3:0] b;
        for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 2) == 0);
        step(md, b);
      end
    end

    // Reset in the middle of GR: outputs return to reset values immediately.
    begin
      int guard;
      guard = 0;
      while (!(m_phase == 2 && m_prev_mode == 3'b100 && m_cnt > 1) && guard < 3000) begin
        step(3'b100, 4'b0000);
        guard++;
      end
      check_val("reach_gr", m_phase, 2);
      check_val("mid_gr_state", int'(state), 5);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (10) step(3'b100, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
